fetch_pc: RTL
=============

Name: fetch_pc

Overview:
- PC register and instruction-fetch sequencer for the RV32I core; sits directly downstream of the branch comparator.
- Consumes the comparator's taken flag plus jump controls, computes the next PC, and issues one-at-a-time requests to instruction memory.
- Delivers fetched instructions to decode over a valid/ready handshake.
- Discards in-flight and held fetches on any redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset; first fetch address.
ADDR_W, 32, PC/address width; fixed at 32 for RV32I.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
br_taken  in  1  branch comparator taken flag (already gated by its enable)
jal  in  1  JAL in execute
jalr  in  1  JALR in execute
br_pc  in  32  PC of the executing branch/jump
br_imm  in  32  sign-extended B/J/I immediate
jalr_rs1  in  32  rs1 value for JALR
imem_req  out  1  fetch request
imem_addr  out  32  fetch address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts
if_pc  out  32  PC of if_instr
if_instr  out  32  instruction word

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - pc_q = RESET_PC, state = FETCH.
  - imem_req = 0 during reset; it asserts in the first cycle after reset is released.
  - if_valid = 0, if_pc = RESET_PC, if_instr = 32'h0000_0013 (NOP).
- Redirect: redirect = jalr | jal | br_taken. Priority when more than one is set: jalr > jal > br_taken.
- Target arithmetic (modulo 2^32, carries dropped):
  - br_taken / jal: br_pc + br_imm.
  - jalr: (jalr_rs1 + br_imm) with bit 0 cleared.
- Sequential PC: pc_q + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
- States:
  - FETCH: imem_req=1, imem_addr=pc_q. On gnt -> WAIT.
  - WAIT: no request. On rvalid: if_instr<=rdata, if_pc<=pc_q, pc_q<=pc_q+4 -> VALID.
  - VALID: if_valid=1, outputs stable. On if_ready -> FETCH.
  - DROP: no request. On rvalid: data discarded -> FETCH.
- Redirect in any state: pc_q<=target at the edge. Next-cycle effects by state:
  - FETCH without gnt: request abandoned; imem_addr shows the target next cycle. Memory must tolerate an address change on an ungranted request.
  - FETCH with gnt the same cycle -> DROP.
  - WAIT without rvalid -> DROP.
  - WAIT with rvalid the same cycle: data discarded -> FETCH.
  - VALID: if_valid deasserts next cycle -> FETCH, whether or not if_ready was set.
  - DROP: stays DROP, or -> FETCH if rvalid arrives the same cycle.
- Outstanding requests: at most one. rvalid is never expected outside WAIT/DROP and is ignored there.
- Latency: gnt in cycle N, rvalid at N+k (k>=1), if_valid at N+k+1. Peak throughput is one instruction per 3 cycles with k=1.
- Stall: if_ready=0 holds VALID indefinitely; no new request is issued while holding.
- Reset asserted mid-transaction: state returns to FETCH at RESET_PC. A stale rvalid arriving after reset release in FETCH is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds outputs trap_valid (1) and trap_tval (32).
  - A redirect target with bit 1 set is not loaded into pc_q.
  - trap_valid pulses one cycle after the redirect cycle, with trap_tval = target.
  - The state machine and in-flight handling behave as for a normal redirect, with pc_q unchanged.
- Undefined: target[1:0] are cleared before loading; no trap ports exist.

Decomposition:
- Shared package rv32i_pkg holds:
  - fetch state enum {FETCH, WAIT, VALID, DROP};
  - the NOP constant 32'h0000_0013;
  - the default RESET_PC.
- One natural sub-module: pc_target, purely combinational. Inputs: redirect controls and operands. Outputs: redirect and target, with priority and bit-0 clearing applied.

Test Plan:
- Reset release, gnt same cycle, rvalid next cycle, if_ready=1 -> fetch addresses 0x0, 0x4, 0x8; if_valid every 3rd cycle with if_pc 0x0, 0x4, 0x8.
- VALID holding if_pc=0x8, if_ready=0 for 5 cycles -> if_valid, if_pc and if_instr stable; imem_req=0 throughout.
- br_taken with br_pc=0x100, br_imm=0xFFFF_FFF0 while in WAIT -> stale rvalid discarded; next imem_addr=0xF0; no if_valid for the discarded word.
- jalr and br_taken together, jalr_rs1=0x203, br_imm=0x4 -> target 0x206 (bit 0 cleared). With FETCH_MISALIGN_TRAP_EN: trap_valid=1, trap_tval=0x206, pc_q unchanged. Without: fetch at 0x204.
- pc_q=0xFFFF_FFFC, accepted fetch -> next imem_addr=0x0000_0000.
- rst_n low while in WAIT, rvalid after release -> rvalid ignored; first request at RESET_PC; if_valid stays 0 until that response.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I front end: fetch state encoding,
// the canonical NOP and the default reset PC.
package rv32i_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential successor; the carry out of bit 31 is dropped so 0xFFFF_FFFC wraps to 0.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_pc_target.sv
// Redirect target generator: combines the execute-stage jump/branch controls
// into a single redirect flag and a priority-resolved target address.
module pc_target #(
    parameter int ADDR_W = 32
) (
    input  logic              br_taken,
    input  logic              jal,
    input  logic              jalr,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_imm,
    input  logic [ADDR_W-1:0] jalr_rs1,
    output logic              redirect,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] pc_rel;
    logic [ADDR_W-1:0] reg_rel;

    assign pc_rel  = br_pc + br_imm;
    assign reg_rel = jalr_rs1 + br_imm;

    // jalr wins over jal and br_taken; jal and br_taken share the PC-relative adder.
    always_comb begin
        redirect = jalr | jal | br_taken;
        target   = pc_rel;
        if (jalr) begin
            target = {reg_rel[ADDR_W-1:1], 1'b0};
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// PC register and single-outstanding instruction fetch sequencer.
// Optional macro FETCH_MISALIGN_TRAP_EN: trap on redirect targets with bit 1 set.
//
// state | meaning
// ------+------------------------------------------------------------
// FETCH | request driven at pc_q, waiting for grant
// WAIT  | request granted, waiting for read data
// VALID | instruction held for decode until if_ready
// DROP  | granted request orphaned by a redirect; swallow its rvalid
module fetch_pc
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_taken,
    input  logic              jal,
    input  logic              jalr,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_imm,
    input  logic [ADDR_W-1:0] jalr_rs1,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              trap_valid,
    output logic [ADDR_W-1:0] trap_tval
`endif
);

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_redirect;
    logic              target_bad;
    logic              capture;

    pc_target #(
        .ADDR_W (ADDR_W)
    ) u_pc_target (
        .br_taken (br_taken),
        .jal      (jal),
        .jalr     (jalr),
        .br_pc    (br_pc),
        .br_imm   (br_imm),
        .jalr_rs1 (jalr_rs1),
        .redirect (redirect),
        .target   (target)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_bad  = target[1];
    assign pc_redirect = target;
`else
    assign target_bad  = 1'b0;
    assign pc_redirect = target & WORD_MASK;
`endif

    // Only a response to a live (non-redirected) request is handed to decode.
    assign capture = (state_q == WAIT) && imem_rvalid && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (imem_gnt) begin
                    state_d = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? FETCH : DROP;
                end else if (imem_rvalid) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (redirect || if_ready) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Request is held low while reset is asserted even though state sits at FETCH.
    always_comb begin
        imem_req  = (state_q == FETCH) && rst_n;
        imem_addr = pc_q;
        if_valid  = (state_q == VALID);
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            if (!target_bad) begin
                pc_d = pc_redirect;
            end
        end else if (capture) begin
            pc_d = seq_pc(pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            if_pc    <= RESET_PC;
            if_instr <= NOP_INSTR;
        end else begin
            pc_q <= pc_d;
            if (capture) begin
                if_pc    <= pc_q;
                if_instr <= imem_rdata;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_valid <= 1'b0;
            trap_tval  <= '0;
        end else begin
            trap_valid <= redirect && target_bad;
            if (redirect && target_bad) begin
                trap_tval <= target;
            end
        end
    end
`endif

endmodule
